// File: rtl/inst_encoder.sv
// RV32I instruction assembler: range-checks the immediate, scatters it into
// the format-specific bit positions and queues encoded words with a
// contiguous instruction-memory word address for an imem loader.
module inst_encoder #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 9,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [7:0]        err_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]       FULL = (PW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    F_LOAD, F_OPIMM, F_STORE, F_LUI, F_JAL, F_JALR, F_BRANCH, F_RTYPE
  } fmt_e;

  logic [31:0]       r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [PW:0]       r_count;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;
  logic [7:0]        r_err_cnt;

  logic [31:0] w_inst;
  logic        w_ok, w_shift, w_sx11, w_sx12, w_sx20;
  logic        w_acc, w_push, w_pop;

  // Sign-extension tests: upper immediate bits must all match the sign bit.
  assign w_sx11  = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign w_sx12  = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign w_sx20  = (&in_imm[31:20]) | ~(|in_imm[31:20]);
  assign w_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

  // Format-specific field placement and immediate range check.
  always_comb begin
    w_inst = '0;
    w_ok   = 1'b1;
    case (fmt_e'(in_fmt))
      F_LOAD: begin
        w_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
        w_ok   = w_sx11;
      end
      F_JALR: begin
        w_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b1100111};
        w_ok   = w_sx11;
      end
      F_OPIMM: begin
        if (w_shift) begin
          w_inst = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
          w_ok   = ~(|in_imm[31:5]);
        end else begin
          w_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
          w_ok   = w_sx11;
        end
      end
      F_STORE: begin
        w_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
        w_ok   = w_sx11;
      end
      F_LUI: begin
        w_inst = {in_imm[31:12], in_rd, 7'b0110111};
        w_ok   = ~(|in_imm[11:0]);
      end
      F_JAL: begin
        w_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
        w_ok   = w_sx20 & ~in_imm[0];
      end
      F_BRANCH: begin
        w_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                  in_imm[4:1], in_imm[11], 7'b1100011};
        w_ok   = w_sx12 & ~in_imm[0];
      end
      default: begin
        w_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
        w_ok   = 1'b1;
      end
    endcase
  end

  // Handshakes: clear blocks both sides; out_ready never reaches in_ready.
  assign in_ready  = reset_n && !clear && (r_count != FULL);
  assign out_valid = (r_count != '0);
  assign w_acc     = in_valid && in_ready;
  assign w_push    = w_acc && w_ok;
  assign w_pop     = out_valid && out_ready && !clear;

  assign out_inst  = r_mem[r_rd_ptr];
  assign out_addr  = r_addr;
  assign err       = r_err;
  assign err_count = r_err_cnt;

  // FIFO storage; zeroed on reset so the idle head reads as 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_inst;
    end
  end

  // Pointers and occupancy; clear flushes everything queued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head address advances only on pops, so rejected requests use no address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   r_addr <= BASE;
    else if (clear) r_addr <= BASE;
    else if (w_pop) r_addr <= r_addr + ADDR_W'(1);
  end

  // Sticky error flag and saturating reject counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (clear) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_acc && !w_ok) begin
      r_err <= 1'b1;
      if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed scenarios plus a randomized
// run against a queue-based reference model running alongside.
module tb_inst_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [8:0]  out_addr;
  logic        err;
  logic [7:0]  err_count;

  // Second instance with a 2-bit address to exercise the wrap.
  logic        d2_clear = 1'b0, d2_in_valid = 1'b0, d2_in_ready, d2_out_valid;
  logic        d2_out_ready = 1'b1, d2_err;
  logic [4:0]  d2_rd = '0;
  logic [31:0] d2_out_inst;
  logic [1:0]  d2_out_addr;
  logic [7:0]  d2_err_count;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  inst_encoder #(.DEPTH(DEPTH), .ADDR_W(9), .BASE_ADDR(0)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .err(err), .err_count(err_count)
  );

  inst_encoder #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .clear(d2_clear), .in_valid(d2_in_valid),
    .in_ready(d2_in_ready), .in_fmt(3'd7), .in_rd(d2_rd), .in_rs1(5'd2),
    .in_rs2(5'd3), .in_funct3(3'd0), .in_funct7(7'd0), .in_imm(32'd0),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_inst(d2_out_inst),
    .out_addr(d2_out_addr), .err(d2_err), .err_count(d2_err_count)
  );

  typedef struct { logic [31:0] inst; int addr; } ent_t;
  ent_t m_q[$];
  int   m_addr = 0;
  bit   m_err = 0;
  int   m_cnt = 0;

  // Reference encoder: ranges as signed-integer bounds, fields by shift/mask.
  function automatic logic [31:0] ref_encode(input logic [2:0] fmt,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
      output bit ok);
    int signed s;
    logic [31:0] base;
    s = $signed(imm);
    base = (32'(rs1) << 15) | (32'(f3) << 12);
    ok = 1;
    case (fmt)
      3'd0, 3'd5: begin
        ok = (s >= -2048) && (s <= 2047);
        return ((imm & 32'hFFF) << 20) | base | (32'(rd) << 7) | ((fmt == 3'd0) ? 32'h03 : 32'h67);
      end
      3'd1: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          ok = (imm < 32);
          return (32'(f7) << 25) | ((imm & 32'h1F) << 20) | base | (32'(rd) << 7) | 32'h13;
        end
        ok = (s >= -2048) && (s <= 2047);
        return ((imm & 32'hFFF) << 20) | base | (32'(rd) << 7) | 32'h13;
      end
      3'd2: begin
        ok = (s >= -2048) && (s <= 2047);
        return (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | base |
               ((imm & 32'h1F) << 7) | 32'h23;
      end
      3'd3: begin
        ok = (imm % 4096) == 0;
        return (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'h37;
      end
      3'd4: begin
        ok = (s >= -1048576) && (s <= 1048575) && ((imm & 1) == 0);
        return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
               (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) |
               (32'(rd) << 7) | 32'h6F;
      end
      3'd6: begin
        ok = (s >= -4096) && (s <= 4095) && ((imm & 1) == 0);
        return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
               (32'(rs2) << 20) | base | (((imm >> 1) & 32'hF) << 8) |
               (((imm >> 11) & 1) << 7) | 32'h63;
      end
      default: return (32'(f7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7) | 32'h33;
    endcase
  endfunction

  // Scoreboard: check every cycle on the falling edge, then apply the
  // effect of the coming rising edge to the model.
  task automatic run_monitor();
    bit exp_rdy, ok;
    logic [31:0] inst;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_q.delete(); m_addr = 0; m_err = 0; m_cnt = 0;
      end
      exp_rdy = reset_n && !clear && (m_q.size() < DEPTH);
      n_chk++;
      if (in_ready !== exp_rdy) begin
        n_err++; $display("FAIL mon_in_ready: got %b want %b at %0t", in_ready, exp_rdy, $time);
      end
      n_chk++;
      if (out_valid !== (m_q.size() != 0)) begin
        n_err++; $display("FAIL mon_out_valid: got %b want %b at %0t", out_valid, m_q.size() != 0, $time);
      end
      if (m_q.size() != 0) begin
        n_chk++;
        if (out_inst !== m_q[0].inst || out_addr !== 9'(m_q[0].addr)) begin
          n_err++;
          $display("FAIL mon_head: got %h@%0d want %h@%0d at %0t", out_inst, out_addr,
                   m_q[0].inst, m_q[0].addr, $time);
        end
      end
      n_chk++;
      if (err !== m_err || err_count !== 8'(m_cnt)) begin
        n_err++; $display("FAIL mon_err: got %b/%0d want %b/%0d at %0t", err, err_count, m_err, m_cnt, $time);
      end
      if (reset_n) begin
        if (clear) begin
          m_q.delete(); m_addr = 0; m_err = 0; m_cnt = 0;
        end else begin
          if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
          if (in_valid && exp_rdy) begin
            inst = ref_encode(in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, ok);
            if (ok) begin
              m_q.push_back('{inst, m_addr});
              m_addr = (m_addr + 1) % 512;
            end else begin
              m_err = 1;
              if (m_cnt < 255) m_cnt++;
            end
          end
        end
      end
    end
  endtask

  // Present one request and hold it until the accepting edge.
  task automatic send(input logic [2:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm);
    bit got;
    in_fmt = fmt; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_chk++;
    if (!got) begin
      n_err++; $display("FAIL send_timeout: got no accept want accept");
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_addr !== 9'd0 ||
        err !== 1'b0 || err_count !== 8'd0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b i=%h a=%0d e=%b c=%0d r=%b want all zero",
               out_valid, out_inst, out_addr, err, err_count, in_ready);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_branch();
    out_ready = 1'b1;
    send(3'd6, 5'd0, 5'd4, 5'd3, 3'd0, 7'd0, 32'd8);
    n_chk++;
    if (out_valid !== 1'b1 || out_inst !== 32'h00320463 || out_addr !== 9'd0) begin
      n_err++; $display("FAIL branch: got %b %h@%0d want 1 00320463@0", out_valid, out_inst, out_addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_i [4] = '{32'hFFF00093, 32'h123452B7, 32'hFFDFF0EF, 32'hFE21AC23};
    do_clear();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
        1: send(3'd3, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        2: send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC);
        default: send(3'd2, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'hFFFFFFF8);
      endcase
      n_chk++;
      if (out_valid !== 1'b1 || out_inst !== exp_i[k] || out_addr !== 9'(k)) begin
        n_err++; $display("FAIL b2b_%0d: got %h@%0d want %h@%0d", k, out_inst, out_addr, exp_i[k], k);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_shifts();
    out_ready = 1'b1;
    send(3'd1, 5'd1, 5'd1, 5'd0, 3'b001, 7'd0, 32'd3);
    n_chk++;
    if (out_inst !== 32'h00309093) begin
      n_err++; $display("FAIL slli: got %h want 00309093", out_inst);
    end
    send(3'd1, 5'd1, 5'd1, 5'd0, 3'b101, 7'b0100000, 32'd3);
    n_chk++;
    if (out_inst !== 32'h4030D093) begin
      n_err++; $display("FAIL srai: got %h want 4030D093", out_inst);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_errors();
    do_clear();
    out_ready = 1'b1;
    send(3'd6, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    n_chk++;
    if (out_valid !== 1'b0 || err !== 1'b1 || err_count !== 8'd1) begin
      n_err++; $display("FAIL err_branch: got v=%b e=%b c=%0d want 0 1 1", out_valid, err, err_count);
    end
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    n_chk++;
    if (err_count !== 8'd2 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL err_opimm: got c=%0d v=%b want 2 0", err_count, out_valid);
    end
    send(3'd0, 5'd2, 5'd1, 5'd0, 3'd2, 7'd0, 32'd4);
    n_chk++;
    if (out_valid !== 1'b1 || out_addr !== 9'd0 || err !== 1'b1) begin
      n_err++; $display("FAIL err_next_addr: got v=%b a=%0d e=%b want 1 0 1", out_valid, out_addr, err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_i [5];
    bit ok, acc_now, accepted;
    int k;
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      exp_i[i] = ref_encode(3'd7, 5'(i + 1), 5'd6, 5'd7, 3'd4, 7'd0, 32'd0, ok);
    for (int i = 0; i < 4; i++) send(3'd7, 5'(i + 1), 5'd6, 5'd7, 3'd4, 7'd0, 32'd0);
    in_rd = 5'd5; in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_chk++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_err++; $display("FAIL bp_full: got r=%b v=%b want 0 1", in_ready, out_valid);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    k = 0; accepted = 0;
    for (int c = 0; c < 20 && k < 5; c++) begin
      @(negedge clk);
      acc_now = in_valid && in_ready;
      if (out_valid) begin
        n_chk++;
        if (out_inst !== exp_i[k] || out_addr !== 9'(k)) begin
          n_err++; $display("FAIL bp_pop_%0d: got %h@%0d want %h@%0d", k, out_inst, out_addr, exp_i[k], k);
        end
        k++;
      end
      @(posedge clk); #1;
      if (acc_now) begin in_valid = 1'b0; accepted = 1; end
    end
    in_valid = 1'b0;
    n_chk++;
    if (k != 5 || !accepted) begin
      n_err++; $display("FAIL bp_drain: got pops=%0d acc=%b want 5 1", k, accepted);
    end
  endtask

  task automatic test_clear();
    do_clear();
    out_ready = 1'b0;
    send(3'd3, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    for (int i = 0; i < 3; i++) send(3'd7, 5'(i), 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
    in_rd = 5'd9; in_valid = 1'b1; out_ready = 1'b1; clear = 1'b1;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL clr_ready: got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || out_addr !== 9'd0 || err !== 1'b0 || err_count !== 8'd0) begin
      n_err++; $display("FAIL clr_state: got v=%b a=%0d e=%b c=%0d want 0 0 0 0",
                        out_valid, out_addr, err, err_count);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
    send(3'd3, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_addr !== 9'd0 ||
        err !== 1'b0 || err_count !== 8'd0 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_mid: got v=%b i=%h a=%0d e=%b c=%0d r=%b want all zero",
                        out_valid, out_inst, out_addr, err, err_count, in_ready);
    end
    @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_err_saturate();
    do_clear();
    in_fmt = 3'd3; in_imm = 32'd1; in_valid = 1'b1;
    repeat (260) @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_chk++;
    if (err_count !== 8'd255 || err !== 1'b1) begin
      n_err++; $display("FAIL err_sat: got %0d/%b want 255/1", err_count, err);
    end
  endtask

  task automatic test_random();
    int bnd [12] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, 31, 32,
                     1048574, -1048576, 1048576};
    do_clear();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      clear     = ($urandom_range(0, 99) < 3);
      in_fmt    = 3'($urandom_range(0, 7));
      in_rd     = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
      in_funct3 = 3'($urandom); in_funct7 = 7'($urandom);
      case ($urandom_range(0, 4))
        0: in_imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        1: in_imm = 32'($urandom);
        2: in_imm = 32'($urandom) & 32'hFFFFF000;
        3: in_imm = 32'($urandom_range(0, 40));
        default: in_imm = 32'(bnd[$urandom_range(0, 11)]);
      endcase
      @(posedge clk); #1;
    end
    in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_addr_wrap();
    int k;
    k = 0;
    d2_out_ready = 1'b1;
    d2_in_valid = 1'b1;
    for (int c = 0; c < 20 && k < 6; c++) begin
      @(negedge clk);
      if (d2_out_valid) begin
        n_chk++;
        if (d2_out_addr !== 2'(k % 4)) begin
          n_err++; $display("FAIL wrap_%0d: got %0d want %0d", k, d2_out_addr, k % 4);
        end
        k++;
      end
      @(posedge clk); #1;
      d2_rd = d2_rd + 5'd1;
    end
    d2_in_valid = 1'b0;
    n_chk++;
    if (k != 6) begin
      n_err++; $display("FAIL wrap_count: got %0d want 6", k);
    end
  endtask

  initial begin
    fork
      run_monitor();
    join_none
    test_reset();
    test_branch();
    test_back_to_back();
    test_shifts();
    test_errors();
    test_backpressure();
    test_clear();
    test_reset_mid();
    test_err_saturate();
    test_random();
    test_addr_wrap();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
